// File: rtl/tf530_bus_top.sv
// Bridge from the accelerator CPU bus to the host 68000 bus: async AS/DS/DTACK cycles,
// 6800-style E/VPA/VMA cycles, and local decode of interrupt-acknowledge and coprocessor cycles.
module tf530_bus_top (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        CLK7M,
  input  logic        AS20,
  input  logic        DS20,
  input  logic        RW20,
  input  logic [2:0]  FC,
  input  logic [1:0]  SIZ,
  input  logic [23:0] A,
  input  logic        INTCYCLE,
  input  logic        SPARE,
  input  logic        IDEWAIT,
  input  logic [2:0]  IPL,
  input  logic        CPSENSE,
  output logic        BG20,
  output logic [1:0]  DSACK,
  output logic        AVEC,
  output logic        BERR,
  output logic        BUSEN,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic        VMA,
  output logic        E,
  input  logic        DTACK,
  input  logic        VPA,
  input  logic        BGACK,
  input  logic        BG
);

  typedef enum logic [2:0] {
    StIdle, StAssert, StWstb, StWait, StSync, StTerm, StHold, StAbort
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  c7_q;
  logic [1:0]  dtack_q, vpa_q, bgack_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        e_q;
  logic        rw_q, rw_d, uds_q, uds_d, lds_q, lds_d;
  logic        ds_on_q, ds_on_d, vma_on_q, vma_on_d;
  logic        as_on_q, busen_on_q, dsack_on_q, avec_on_q, berr_on_q;
  logic        c7_rise, c7_fall, iack, cpsp, host_req, start;
  logic        unused_ok;

  assign unused_ok = ^{DS20, IDEWAIT, IPL, A[23:20], A[15:1]};

  // c7_q[2] is the previous synchronised sample, so edges are seen 2-3 CLKCPU late
  assign c7_rise = c7_q[1] & ~c7_q[2];
  assign c7_fall = ~c7_q[1] & c7_q[2];

  assign iack     = (FC == 3'b111) && (A[19:16] == 4'hF);
  assign cpsp     = (FC == 3'b111) && (A[19:16] == 4'h2) && CPSENSE;
  assign host_req = ~AS20 & ~iack & ~cpsp & ~INTCYCLE & ~SPARE;
  assign start    = (state_q == StIdle) && (state_d == StAssert);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (host_req && bgack_q[1] && c7_fall) state_d = StAssert;
      StAssert: if (AS20) state_d = StAbort;
                else if (c7_rise) state_d = rw_q ? StWait : StWstb;
      StWstb:   if (AS20) state_d = StAbort;
                else if (c7_fall) state_d = StWait;
      StWait:   if (AS20) state_d = StAbort;
                else if (c7_rise) begin
                  if (!dtack_q[1]) state_d = StTerm;
                  else if (!vpa_q[1]) state_d = StSync;
                end
      // Terminate on the E falling edge, i.e. the 9 -> 0 counter wrap
      StSync:   if (AS20) state_d = StAbort;
                else if (c7_rise && vma_on_q && cnt_q == 4'd9) state_d = StTerm;
      StTerm:   if (c7_fall) state_d = StHold;
      StHold:   if (AS20) state_d = StIdle;
      StAbort:  if (c7_fall) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = c7_rise ? ((cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1) : cnt_q;
    rw_d     = rw_q;
    uds_d    = uds_q;
    lds_d    = lds_q;
    ds_on_d  = ds_on_q;
    vma_on_d = vma_on_q;
    if (start) begin
      rw_d    = RW20;
      uds_d   = (SIZ == 2'b10) || (SIZ == 2'b01 && !A[0]);
      lds_d   = (SIZ == 2'b10) || (SIZ == 2'b01 && A[0]);
      ds_on_d = RW20;
    end
    if (state_d == StWstb) ds_on_d = 1'b1;
    if (state_q == StSync && cnt_q == 4'd3) vma_on_d = 1'b1;
    if (state_d == StIdle || state_d == StHold) begin
      ds_on_d  = 1'b0;
      vma_on_d = 1'b0;
    end
    if (state_d == StIdle) rw_d = 1'b1;
  end

  // Outputs are registered from next-state so host strobes never glitch
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      c7_q       <= 3'b000;
      dtack_q    <= 2'b11;
      vpa_q      <= 2'b11;
      bgack_q    <= 2'b11;
      cnt_q      <= 4'd0;
      e_q        <= 1'b0;
      rw_q       <= 1'b1;
      uds_q      <= 1'b0;
      lds_q      <= 1'b0;
      ds_on_q    <= 1'b0;
      vma_on_q   <= 1'b0;
      as_on_q    <= 1'b0;
      busen_on_q <= 1'b0;
      dsack_on_q <= 1'b0;
      avec_on_q  <= 1'b0;
      berr_on_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      c7_q       <= {c7_q[1:0], CLK7M};
      dtack_q    <= {dtack_q[0], DTACK};
      vpa_q      <= {vpa_q[0], VPA};
      bgack_q    <= {bgack_q[0], BGACK};
      cnt_q      <= cnt_d;
      e_q        <= (cnt_d >= 4'd6);
      rw_q       <= rw_d;
      uds_q      <= uds_d;
      lds_q      <= lds_d;
      ds_on_q    <= ds_on_d;
      vma_on_q   <= vma_on_d;
      as_on_q    <= !(state_d == StIdle || state_d == StHold);
      busen_on_q <= (state_d != StIdle);
      dsack_on_q <= (state_d == StTerm || state_d == StHold) && !AS20;
      avec_on_q  <= ~AS20 & iack;
      berr_on_q  <= ~AS20 & cpsp;
    end
  end

  assign AS    = BGACK ? ~as_on_q : 1'bz;
  assign UDS   = BGACK ? ~(ds_on_q & uds_q) : 1'bz;
  assign LDS   = BGACK ? ~(ds_on_q & lds_q) : 1'bz;
  assign RW    = BGACK ? rw_q : 1'bz;
  assign VMA   = BGACK ? ~vma_on_q : 1'bz;
  assign BUSEN = ~(busen_on_q & BGACK);
  assign DSACK = dsack_on_q ? 2'b01 : 2'b11;
  assign AVEC  = ~avec_on_q;
  assign BERR  = ~berr_on_q;
  assign E     = e_q;
  assign BG20  = BG;

endmodule

// File: tb/tb_tf530_bus_top.sv
// Directed bench for tf530_bus_top: CLKCPU 100 MHz, CLK7M 12.5 MHz (8:1, phase-offset).
module tb_tf530_bus_top;

  logic        clk_cpu = 1'b0;
  logic        clk7m = 1'b0;
  logic        rst_n, as20, ds20, rw20, intcycle, spare, idewait, cpsense;
  logic [2:0]  fc, ipl;
  logic [1:0]  siz;
  logic [23:0] addr;
  logic        dtack, vpa, bgack, bg;
  logic        bg20, avec, berr, busen, e_clk;
  logic [1:0]  dsack;
  wire         host_as, uds, lds, host_rw, vma;

  int checks = 0;
  int errors = 0;
  int n, k;
  logic bad;

  tf530_bus_top dut (
    .CLKCPU(clk_cpu), .RESET(rst_n), .CLK7M(clk7m), .AS20(as20), .DS20(ds20), .RW20(rw20),
    .FC(fc), .SIZ(siz), .A(addr), .INTCYCLE(intcycle), .SPARE(spare), .IDEWAIT(idewait),
    .IPL(ipl), .CPSENSE(cpsense), .BG20(bg20), .DSACK(dsack), .AVEC(avec), .BERR(berr),
    .BUSEN(busen), .AS(host_as), .UDS(uds), .LDS(lds), .RW(host_rw), .VMA(vma), .E(e_clk),
    .DTACK(dtack), .VPA(vpa), .BGACK(bgack), .BG(bg)
  );

  always #5 clk_cpu = ~clk_cpu;
  initial begin
    #2;
    forever #40 clk7m = ~clk7m;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(posedge clk_cpu);
    #1;
  endtask

  task automatic cpu_start(input logic [2:0] f, input logic [23:0] a, input logic [1:0] s,
                           input logic r);
    fc = f; addr = a; siz = s; rw20 = r; as20 = 1'b0; ds20 = 1'b0;
  endtask

  task automatic cpu_end();
    as20 = 1'b1; ds20 = 1'b1; dtack = 1'b1; vpa = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; as20 = 1'b1; ds20 = 1'b1; rw20 = 1'b1; fc = 3'b101; siz = 2'b10;
    addr = 24'h0; intcycle = 1'b0; spare = 1'b0; idewait = 1'b0; ipl = 3'b111;
    cpsense = 1'b1; dtack = 1'b1; vpa = 1'b1; bgack = 1'b1; bg = 1'b0;

    // Reset state
    tick(3);
    check_eq("rst_as", host_as, 1'b1);
    check_eq("rst_uds_lds", {uds, lds}, 2'b11);
    check_eq("rst_rw_vma", {host_rw, vma}, 2'b11);
    check_eq("rst_dsack", dsack, 2'b11);
    check_eq("rst_avec_berr", {avec, berr}, 2'b11);
    check_eq("rst_busen", busen, 1'b1);
    check_eq("rst_e", e_clk, 1'b0);
    check_eq("bg20_lo", bg20, 1'b0);
    bg = 1'b1; #1;
    check_eq("bg20_hi", bg20, 1'b1);
    rst_n = 1'b1;
    tick(4);

    // E generator: high 4 CLK7M (32 CLKCPU), low 6 CLK7M (48 CLKCPU)
    n = 0;
    while (e_clk !== 1'b1 && n < 200) begin tick(1); n++; end
    check_eq("e_rise_to", n < 200, 1'b1);
    k = 0;
    while (e_clk !== 1'b0 && k < 200) begin tick(1); k++; end
    check_eq("e_high_len", k, 32);
    k = 0;
    while (e_clk !== 1'b1 && k < 200) begin tick(1); k++; end
    check_eq("e_low_len", k, 48);

    // Word read at 0x000000
    cpu_start(3'b101, 24'h000000, 2'b10, 1'b1);
    n = 0;
    while (host_as !== 1'b0 && n < 200) begin tick(1); n++; end
    check_eq("rd_as_to", n < 200, 1'b1);
    check_eq("rd_uds_lds", {uds, lds}, 2'b00);
    check_eq("rd_rw", host_rw, 1'b1);
    check_eq("rd_busen", busen, 1'b0);
    @(posedge clk7m); @(posedge clk7m); tick(1);
    check_eq("rd_no_early_dsack", dsack, 2'b11);
    check_eq("rd_as_held", host_as, 1'b0);
    dtack = 1'b0;
    n = 0;
    while (dsack !== 2'b01 && n < 100) begin tick(1); n++; end
    check_eq("rd_dsack", dsack, 2'b01);
    cpu_end();
    tick(20);
    check_eq("rd_rel_strobes", {host_as, uds, lds}, 3'b111);
    check_eq("rd_rel_dsack", dsack, 2'b11);
    check_eq("rd_rel_busen_rw", {busen, host_rw}, 2'b11);

    // Byte write at 0xDFF031: LDS follows AS by one CLK7M half-period
    cpu_start(3'b101, 24'hDFF031, 2'b01, 1'b0);
    n = 0;
    while (host_as !== 1'b0 && n < 200) begin tick(1); n++; end
    check_eq("wr_as_to", n < 200, 1'b1);
    check_eq("wr_rw", host_rw, 1'b0);
    check_eq("wr_lds_late", lds, 1'b1);
    k = 0;
    while (lds !== 1'b0 && k < 50) begin tick(1); k++; end
    check_eq("wr_lds_delay", k, 4);
    check_eq("wr_uds", uds, 1'b1);
    dtack = 1'b0;
    n = 0;
    while (dsack !== 2'b01 && n < 100) begin tick(1); n++; end
    check_eq("wr_dsack", dsack, 2'b01);
    cpu_end();
    tick(20);
    check_eq("wr_rel", {host_as, uds, lds, host_rw}, 4'b1111);

    // VPA cycle at 0xBFE001
    cpu_start(3'b101, 24'hBFE001, 2'b01, 1'b1);
    n = 0;
    while (host_as !== 1'b0 && n < 200) begin tick(1); n++; end
    check_eq("vpa_as_to", n < 200, 1'b1);
    check_eq("vpa_lanes", {uds, lds}, 2'b10);
    vpa = 1'b0;
    n = 0;
    while (vma !== 1'b0 && n < 2000) begin tick(1); n++; end
    check_eq("vpa_vma_to", n < 2000, 1'b1);
    check_eq("vpa_vma_e", e_clk, 1'b0);
    k = 0;
    while (e_clk !== 1'b1 && k < 200) begin tick(1); k++; end
    check_eq("vpa_vma_to_e", k, 23);
    check_eq("vpa_no_dsack_e_hi", dsack, 2'b11);
    n = 0;
    while (dsack !== 2'b01 && n < 200) begin tick(1); n++; end
    check_eq("vpa_dsack", dsack, 2'b01);
    check_eq("vpa_e_fell", e_clk, 1'b0);
    cpu_end();
    tick(20);
    check_eq("vpa_rel", {host_as, vma, lds}, 3'b111);

    // Claimed by on-card logic
    intcycle = 1'b1;
    cpu_start(3'b101, 24'h200000, 2'b10, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick(1);
      if (host_as !== 1'b1 || busen !== 1'b1 || dsack !== 2'b11) bad = 1'b1;
    end
    check_eq("intcyc_quiet", bad, 1'b0);
    cpu_end();
    intcycle = 1'b0;
    tick(4);

    // Interrupt acknowledge
    cpu_start(3'b111, 24'h0F0000, 2'b01, 1'b1);
    tick(2);
    check_eq("iack_avec", avec, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (host_as !== 1'b1 || dsack !== 2'b11 || avec !== 1'b0) bad = 1'b1;
    end
    check_eq("iack_no_host", bad, 1'b0);
    cpu_end();
    tick(1);
    check_eq("iack_release", avec, 1'b1);

    // Coprocessor space, no FPU
    cpu_start(3'b111, 24'h020000, 2'b10, 1'b1);
    tick(2);
    check_eq("cp_berr", berr, 1'b0);
    tick(40);
    check_eq("cp_no_host", {host_as, avec}, 2'b11);
    cpu_end();
    tick(1);
    check_eq("cp_release", berr, 1'b1);
    tick(4);

    // Arbitration: no cycle while BGACK low
    bgack = 1'b0;
    cpu_start(3'b101, 24'h000000, 2'b10, 1'b1);
    tick(100);
    check_eq("arb_busen", busen, 1'b1);
    check_eq("arb_dsack", dsack, 2'b11);
    bgack = 1'b1;
    n = 0;
    while (host_as !== 1'b0 && n < 200) begin tick(1); n++; end
    check_eq("arb_as_after", n < 200, 1'b1);
    dtack = 1'b0;
    n = 0;
    while (dsack !== 2'b01 && n < 100) begin tick(1); n++; end
    check_eq("arb_dsack_after", dsack, 2'b01);
    cpu_end();
    tick(20);

    // Reset mid-cycle while E is high
    cpu_start(3'b101, 24'h000000, 2'b10, 1'b1);
    n = 0;
    while (host_as !== 1'b0 && n < 200) begin tick(1); n++; end
    check_eq("mid_as_to", n < 200, 1'b1);
    n = 0;
    while (e_clk !== 1'b1 && n < 1000) begin tick(1); n++; end
    check_eq("mid_e_to", n < 1000, 1'b1);
    check_eq("mid_busen_pre", busen, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_strobes", {host_as, uds, lds}, 3'b111);
    check_eq("mid_dsack", dsack, 2'b11);
    check_eq("mid_busen", busen, 1'b1);
    check_eq("mid_e", e_clk, 1'b0);
    cpu_end();
    tick(2);
    rst_n = 1'b1;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
